// File: rtl/counter_pkg.sv
// Shared constants for the counter family: count direction, boundary mode
// and default sizing used by the blocks that instantiate param_counter.
package counter_pkg;

    localparam int   DEFAULT_WIDTH  = 32;
    localparam int   DEFAULT_STEP_W = 8;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-count calculation for param_counter: one up/down step
// against an inclusive 0..limit range with wrap or saturate at the ends.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic [WIDTH-1:0]  value_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic              mode_i,
    output logic [WIDTH-1:0]  next_value_o,
    output logic              boundary_hit_o
);

    // One spare bit above the wider operand keeps every intermediate exact.
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [CW-1:0] val_x_s;
    logic [CW-1:0] step_x_s;
    logic [CW-1:0] lim_x_s;
    logic [CW-1:0] lim_p1_s;
    logic [CW-1:0] sum_up_s;
    logic [CW-1:0] wrap_up_s;
    logic [CW-1:0] dn_room_s;

    assign val_x_s   = CW'(value_i);
    assign step_x_s  = CW'(step_i);
    assign lim_x_s   = CW'(limit_i);
    assign lim_p1_s  = lim_x_s + CW'(1'b1);
    assign sum_up_s  = val_x_s + step_x_s;
    assign wrap_up_s = sum_up_s - lim_p1_s;
    assign dn_room_s = val_x_s + lim_p1_s;

    // Select the stepped value and flag whether a range boundary was crossed.
    always_comb begin
        next_value_o   = value_i;
        boundary_hit_o = 1'b0;
        if (step_i == {STEP_W{1'b0}}) begin
            next_value_o   = value_i;
            boundary_hit_o = 1'b0;
        end else if (dir_i == DIR_UP) begin
            if (sum_up_s <= lim_x_s) begin
                next_value_o   = WIDTH'(sum_up_s);
                boundary_hit_o = 1'b0;
            end else begin
                boundary_hit_o = 1'b1;
                if (mode_i == MODE_SAT) begin
                    next_value_o = limit_i;
                end else if (wrap_up_s > lim_x_s) begin
                    // A step wider than the whole range cannot land inside it.
                    next_value_o = limit_i;
                end else begin
                    next_value_o = WIDTH'(wrap_up_s);
                end
            end
        end else begin
            if (step_x_s <= val_x_s) begin
                next_value_o   = WIDTH'(val_x_s - step_x_s);
                boundary_hit_o = 1'b0;
            end else begin
                boundary_hit_o = 1'b1;
                if (mode_i == MODE_SAT) begin
                    next_value_o = {WIDTH{1'b0}};
                end else if (step_x_s > dn_room_s) begin
                    next_value_o = {WIDTH{1'b0}};
                end else begin
                    next_value_o = WIDTH'(dn_room_s - step_x_s);
                end
            end
        end
    end

endmodule : counter_next

// File: rtl/param_counter.sv
// General event/cycle counter: programmable step and limit, up/down, wrap or
// saturate, synchronous clear/load, registered terminal-count and sticky overflow.
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int STEP_W   = DEFAULT_STEP_W,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  value,
    output logic              tc,
    output logic              ovf
);

    localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] next_value_s;
    logic             boundary_hit_s;

    counter_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .value_i        (value_q),
        .dir_i          (dir),
        .step_i         (step),
        .limit_i        (limit),
        .mode_i         (MODE),
        .next_value_o   (next_value_s),
        .boundary_hit_o (boundary_hit_s)
    );

    assign load_clamped_s = (load_val > limit) ? limit : load_val;

    // Priority mux: clear, then load, then count, otherwise hold.
    always_comb begin
        value_d = value_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = {WIDTH{1'b0}};
            tc_d    = 1'b0;
            ovf_d   = 1'b0;
        end else if (load) begin
            value_d = load_clamped_s;
            tc_d    = 1'b0;
            ovf_d   = ovf_q;
        end else if (en) begin
            value_d = next_value_s;
            tc_d    = boundary_hit_s;
            ovf_d   = ovf_q | boundary_hit_s;
        end else begin
            value_d = value_q;
            tc_d    = 1'b0;
            ovf_d   = ovf_q;
        end
    end

    // Count, terminal-count and overflow state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= {WIDTH{1'b0}};
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations share one stimulus stream and
// are compared every cycle against an integer reference model.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic       load;
    logic       dir;
    logic [8:0] load_val;
    logic [8:0] limit;
    logic [7:0] step;

    logic [7:0] v0, v1;
    logic [8:0] v2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    int n_checks = 0;
    int n_errors = 0;

    longint m_val [3];
    bit     m_tc  [3];
    bit     m_ovf [3];
    int     m_w   [3] = '{8, 8, 9};
    bit     m_sat [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    param_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(0)) u_wrap8 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val[7:0]), .dir(dir), .step(step), .limit(limit[7:0]),
        .value(v0), .tc(tc0), .ovf(ovf0));

    param_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(1)) u_sat8 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val[7:0]), .dir(dir), .step(step), .limit(limit[7:0]),
        .value(v1), .tc(tc1), .ovf(ovf1));

    param_counter #(.WIDTH(9), .STEP_W(8), .SATURATE(0)) u_wrap9 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .step(step), .limit(limit),
        .value(v2), .tc(tc2), .ovf(ovf2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic straight from the counting rules.
    function automatic void model_step(int i);
        longint mask = (64'd1 << m_w[i]) - 1;
        longint lim  = longint'(limit) & mask;
        longint lv   = longint'(load_val) & mask;
        longint v    = m_val[i];
        longint s    = longint'(step);
        bit     t    = 1'b0;
        if (clr) begin
            m_val[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            return;
        end
        if (load) begin
            v = (lv < lim) ? lv : lim;
        end else if (en && s != 0) begin
            if (dir) begin
                if (v + s <= lim) v = v + s;
                else begin
                    t = 1'b1;
                    if (m_sat[i]) v = lim;
                    else begin
                        v = v + s - (lim + 1);
                        if (v > lim) v = lim;
                    end
                end
            end else begin
                if (s <= v) v = v - s;
                else begin
                    t = 1'b1;
                    if (m_sat[i] || s > v + lim + 1) v = 0;
                    else v = v + lim + 1 - s;
                end
            end
        end
        m_val[i] = v;
        m_tc[i]  = t;
        m_ovf[i] = m_ovf[i] | t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [31:0] gv [3];
        logic [31:0] gt [3];
        logic [31:0] go [3];
        gv[0] = 32'(v0);  gv[1] = 32'(v1);  gv[2] = 32'(v2);
        gt[0] = 32'(tc0); gt[1] = 32'(tc1); gt[2] = 32'(tc2);
        go[0] = 32'(ovf0); go[1] = 32'(ovf1); go[2] = 32'(ovf2);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("dut%0d_value", i), gv[i], 32'(m_val[i]));
            check_eq($sformatf("dut%0d_tc", i),    gt[i], 32'(m_tc[i]));
            check_eq($sformatf("dut%0d_ovf", i),   go[i], 32'(m_ovf[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        check_all();
    endtask

    // Assert reset between clock edges and check outputs fall without a clock.
    task automatic async_reset_pulse();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 reset_n = 1'b1;
    endtask

    int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        reset_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1;
        step = 8'd0; load_val = 9'd0; limit = 9'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk) reset_n = 1'b1;

        // Plan 1: wrap at limit 9.
        limit = 9'd9; step = 8'd1; dir = 1'b1; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("t1_value", 32'(v0), 32'(exp1[k]));
            check_eq("t1_tc", 32'(tc0), (exp1[k] == 0) ? 32'd1 : 32'd0);
        end
        check_eq("t1_ovf", 32'(ovf0), 32'd1);

        // Plan 2: saturate at 200.
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        limit = 9'd200; load_val = 9'd198; load = 1'b1; tick(); load = 1'b0;
        check_eq("t2_load", 32'(v1), 32'd198);
        step = 8'd3; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t2_value", 32'(v1), 32'd200);
            check_eq("t2_tc", 32'(tc1), 32'd1);
        end
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        check_eq("t2_clr_value", 32'(v1), 32'd0);
        check_eq("t2_clr_ovf", 32'(ovf1), 32'd0);

        // Plan 3: down wrap through zero, then step 0 holds.
        limit = 9'd255; load_val = 9'd2; load = 1'b1; tick(); load = 1'b0;
        dir = 1'b0; step = 8'd5; en = 1'b1; tick();
        check_eq("t3_value", 32'(v0), 32'd253);
        check_eq("t3_tc", 32'(tc0), 32'd1);
        step = 8'd0; tick();
        check_eq("t3_hold", 32'(v0), 32'd253);
        check_eq("t3_hold_tc", 32'(tc0), 32'd0);

        // Plan 4: priority, and load clamped to limit.
        en = 1'b0; load_val = 9'd7; load = 1'b1; tick();
        check_eq("t4_load7", 32'(v0), 32'd7);
        clr = 1'b1; load = 1'b1; en = 1'b1; tick(); clr = 1'b0;
        check_eq("t4_clr_wins", 32'(v0), 32'd0);
        limit = 9'd100; load_val = 9'd300; load = 1'b1; en = 1'b1; dir = 1'b1; step = 8'd1;
        tick();
        check_eq("t4_clamp", 32'(v2), 32'd100);
        check_eq("t4_clamp_tc", 32'(tc2), 32'd0);
        load = 1'b0; en = 1'b0;

        // Plan 5: asynchronous reset mid-count.
        limit = 9'd255; load_val = 9'h55; load = 1'b1; tick(); load = 1'b0;
        check_eq("t5_load", 32'(v0), 32'h55);
        async_reset_pulse();
        check_eq("t5_rst_value", 32'(v0), 32'd0);
        check_eq("t5_rst_ovf", 32'(ovf0), 32'd0);
        en = 1'b1; dir = 1'b1; step = 8'd1; tick();
        check_eq("t5_resume", 32'(v0), 32'd1);

        // Plan 6: limit lowered below the current count.
        en = 1'b0; limit = 9'd99; load_val = 9'd50; load = 1'b1; tick(); load = 1'b0;
        limit = 9'd20; en = 1'b1; dir = 1'b1; step = 8'd1; tick();
        check_eq("t6_value", 32'(v0), 32'd20);
        check_eq("t6_tc", 32'(tc0), 32'd1);

        // Randomized traffic.
        limit = 9'($urandom_range(0, 300));
        for (int n = 0; n < 500; n++) begin
            clr      = ($urandom_range(0, 24) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            load_val = 9'($urandom_range(0, 511));
            case ($urandom_range(0, 3))
                0:       step = 8'd0;
                1:       step = 8'd1;
                2:       step = 8'($urandom_range(0, 7));
                default: step = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 15) == 0) limit = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 59) == 0) async_reset_pulse();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_param_counter
